puf_uart_seq: RTL



---
 rtl/puf_if_pkg.sv | 24 ++
 rtl/puf_seq_edge.sv | 22 ++
 rtl/puf_uart_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_if_pkg.sv
// Shared definitions for the PUF command sequencer.
//   state_t        : sequencer FSM states
//   SYNC_BYTE_DEF  : default header byte that opens a command
//   ERR_BYTE_DEF   : default byte returned to the host on PUF timeout
//   max2()         : elaboration-time helper for counter sizing
package puf_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_CHAL,
    START,
    WAIT_PUF,
    TX_LOAD,
    TX_WAIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_seq_edge.sv
// 1-bit registered rising-edge detector.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears the history bit)
//   level : input level to watch
//   evt   : single-cycle pulse when level goes 0->1; a held level fires once
module puf_seq_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic evt
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign evt = level & ~prev;

endmodule

// File: rtl/puf_uart_seq.sv
// Command sequencer between a UART receiver/transmitter pair and a PUF core.
// Hunts for SYNC_BYTE, assembles a CHAL_BYTES challenge (first byte in the
// top byte), pulses the PUF, then returns RESP_BYTES response bytes MSB-first,
// one per transmitter handshake. RX inter-byte gap and PUF latency are both
// bounded by TIMEOUT_CYC; a PUF timeout returns ERR_BYTE instead.
//
// Optional build macro PUF_SEQ_CHECKSUM_EN: append one XOR byte of all bytes
// sent (ERR_BYTE followed by ERR_BYTE in error mode).
//
// Ports:
//   sys_clk        in   system clock, rising edge
//   sys_rstH       in   synchronous active-high reset
//   rec_dataH      in   received byte
//   rec_readyH     in   receiver byte-ready level (consumed on 0->1)
//   xmitH          out  one-cycle transmit request
//   xmit_dataH     out  byte to transmit, stable until the done edge
//   xmit_doneH     in   transmitter done level (complete on 0->1)
//   puf_challengeH out  assembled challenge
//   puf_startH     out  one-cycle PUF launch
//   puf_doneH      in   PUF result valid level
//   puf_responseH  in   PUF result, captured on the first done cycle
//   busyH          out  high whenever not IDLE
//   errorH         out  one-cycle pulse on any timeout
module puf_uart_seq
  import puf_if_pkg::*;
#(
  parameter int         CHAL_BYTES  = 8,
  parameter int         RESP_BYTES  = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE    = ERR_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rstH,
  input  logic [7:0]              rec_dataH,
  input  logic                    rec_readyH,
  output logic                    xmitH,
  output logic [7:0]              xmit_dataH,
  input  logic                    xmit_doneH,
  output logic [CHAL_BYTES*8-1:0] puf_challengeH,
  output logic                    puf_startH,
  input  logic                    puf_doneH,
  input  logic [RESP_BYTES*8-1:0] puf_responseH,
  output logic                    busyH,
  output logic                    errorH
);

  localparam int CHAL_W = CHAL_BYTES * 8;
  localparam int RESP_W = RESP_BYTES * 8;
  localparam int CNT_W  = $clog2(max2(CHAL_BYTES, RESP_BYTES) + 2);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC);

`ifdef PUF_SEQ_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [CNT_W-1:0]  CHAL_LAST = CNT_W'(CHAL_BYTES - 1);
  localparam logic [CNT_W-1:0]  RESP_LAST = CNT_W'(RESP_BYTES - 1 + EXTRA);
  localparam logic [CNT_W-1:0]  ERR_LAST  = CNT_W'(EXTRA);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RESP_W-1:0] ERR_INIT  = RESP_W'(ERR_BYTE) << (RESP_W - 8);

  state_t state, state_next;

  logic              rx_evt, tx_evt;
  logic [CHAL_W-1:0] chal;
  logic [RESP_W-1:0] resp_sr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TMO_W-1:0]  tmo;
  logic              err_mode;
  logic              done_seen;
  logic              tmo_hit;
  logic [CNT_W-1:0]  tx_last;
  logic [7:0]        top_byte;
  logic [7:0]        tx_byte;

  // control strobes from the FSM to the datapath
  logic chal_shift, cnt_clr, cnt_inc, tmo_clr, tmo_run;
  logic resp_cap, err_cap, resp_shift;
  logic err_pulse, start_pulse, xmit_pulse;

  puf_seq_edge u_rx_edge (
    .clk   (sys_clk),
    .rst   (sys_rstH),
    .level (rec_readyH),
    .evt   (rx_evt)
  );

  puf_seq_edge u_tx_edge (
    .clk   (sys_clk),
    .rst   (sys_rstH),
    .level (xmit_doneH),
    .evt   (tx_evt)
  );

  assign tmo_hit  = (tmo == TMO_LAST);
  assign tx_last  = err_mode ? ERR_LAST : RESP_LAST;
  assign top_byte = resp_sr[RESP_W-1 -: 8];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk) begin
    if (sys_rstH) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    chal_shift  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    tmo_clr     = 1'b0;
    tmo_run     = 1'b0;
    resp_cap    = 1'b0;
    err_cap     = 1'b0;
    resp_shift  = 1'b0;
    err_pulse   = 1'b0;
    start_pulse = 1'b0;
    xmit_pulse  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_evt && (rec_dataH == SYNC_BYTE)) begin
          state_next = RX_CHAL;
          cnt_clr    = 1'b1;
          tmo_clr    = 1'b1;
        end
      end
      RX_CHAL: begin
        // a sync byte here is ordinary challenge data
        if (rx_evt) begin
          chal_shift = 1'b1;
          cnt_inc    = 1'b1;
          tmo_clr    = 1'b1;
          if (byte_cnt == CHAL_LAST) state_next = START;
        end else if (tmo_hit) begin
          err_pulse  = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_run = 1'b1;
        end
      end
      START: begin
        start_pulse = 1'b1;
        tmo_clr     = 1'b1;
        state_next  = WAIT_PUF;
      end
      WAIT_PUF: begin
        // The response is captured on the first done cycle; the move to
        // TX_LOAD happens one cycle later, giving done->xmit of two cycles.
        // Done is checked before timeout, so it wins a same-cycle tie.
        if (done_seen) begin
          state_next = TX_LOAD;
        end else if (puf_doneH) begin
          resp_cap = 1'b1;
          cnt_clr  = 1'b1;
        end else if (tmo_hit) begin
          err_pulse  = 1'b1;
          err_cap    = 1'b1;
          cnt_clr    = 1'b1;
          state_next = TX_LOAD;
        end else begin
          tmo_run = 1'b1;
        end
      end
      TX_LOAD: begin
        xmit_pulse = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_evt) begin
          resp_shift = 1'b1;
          cnt_inc    = 1'b1;
          state_next = (byte_cnt == tx_last) ? IDLE : TX_LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      // NOTE: the shift registers drive outputs directly, so they are reset
      // along with the control state rather than left uninitialised.
      chal      <= '0;
      resp_sr   <= '0;
      byte_cnt  <= '0;
      tmo       <= '0;
      err_mode  <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      if (chal_shift) chal <= (chal << 8) | CHAL_W'(rec_dataH);

      if (cnt_clr)      byte_cnt <= '0;
      else if (cnt_inc) byte_cnt <= byte_cnt + CNT_W'(1);

      // saturates at the terminal value; the FSM leaves the state there anyway
      if (tmo_clr)                          tmo <= '0;
      else if (tmo_run && !tmo_hit)         tmo <= tmo + TMO_W'(1);

      if (resp_cap) begin
        resp_sr   <= puf_responseH;
        err_mode  <= 1'b0;
        done_seen <= 1'b1;
      end else if (err_cap) begin
        resp_sr  <= ERR_INIT;
        err_mode <= 1'b1;
      end else if (resp_shift) begin
        resp_sr <= resp_sr << 8;
      end

      if (start_pulse) done_seen <= 1'b0;
    end
  end

`ifdef PUF_SEQ_CHECKSUM_EN
  logic [7:0]       csum;
  logic             csum_phase;
  logic [CNT_W-1:0] n_data;

  // checksum byte follows the last data byte (1 in error mode)
  assign n_data     = err_mode ? CNT_W'(1) : CNT_W'(RESP_BYTES);
  assign csum_phase = (byte_cnt == n_data);
  assign tx_byte    = csum_phase ? csum : top_byte;

  always_ff @(posedge sys_clk) begin
    if (sys_rstH)                 csum <= '0;
    else if (resp_cap || err_cap) csum <= '0;
    else if (resp_shift)          csum <= csum ^ tx_byte;
  end
`else
  assign tx_byte = top_byte;
`endif

  // Pulses and busy are masked by reset so they drop in the reset cycle itself.
  assign xmitH          = xmit_pulse  & ~sys_rstH;
  assign puf_startH     = start_pulse & ~sys_rstH;
  assign errorH         = err_pulse   & ~sys_rstH;
  assign busyH          = (state != IDLE) & ~sys_rstH;
  assign xmit_dataH     = tx_byte;
  assign puf_challengeH = chal;

endmodule
